// File: rtl/wb_regfile.sv
// ============================================================================
// Module  : wb_regfile
// Purpose : MIPS write-back stage: destination/data select, 32-entry register
//           file with same-cycle write bypass on both ID read ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int RA_REG = 31,
  parameter int XP_REG = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       WB_PC_4,
  input  logic [1:0]        WB_RegDst,
  input  logic [1:0]        WB_MemToReg,
  input  logic              WB_RegWr,
  input  logic [DATA_W-1:0] WB_ALUOut,
  input  logic [DATA_W-1:0] WB_dataMEMOut,
  input  logic [4:0]        WB_Rt,
  input  logic [4:0]        WB_Rd,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [15:0]       wr_count
);

  localparam logic [4:0]  c_RA_IDX = 5'(RA_REG);
  localparam logic [4:0]  c_XP_IDX = 5'(XP_REG);
  localparam logic [31:0] c_PC_STEP = 32'd4;

  logic [DATA_W-1:0] regs_q [32];
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic [31:0]       w_pc_prev;

  assign w_pc_prev  = WB_PC_4 - c_PC_STEP;
  assign wr_count_d = wr_count_q + 16'd1;

  always_comb begin
    wb_addr = WB_Rt;
    case (WB_RegDst)
      2'b00:   wb_addr = WB_Rt;
      2'b01:   wb_addr = WB_Rd;
      2'b10:   wb_addr = c_RA_IDX;
      default: wb_addr = c_XP_IDX;
    endcase
  end

  always_comb begin
    wb_data = WB_ALUOut;
    case (WB_MemToReg)
      2'b00:   wb_data = WB_ALUOut;
      2'b01:   wb_data = WB_dataMEMOut;
      2'b10:   wb_data = DATA_W'(WB_PC_4);
      default: wb_data = DATA_W'(w_pc_prev);
    endcase
  end

  // Gating with reset keeps the bypass and forwarding quiet while in reset.
  assign wb_we = reset & WB_RegWr & (wb_addr != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (wb_we) begin
      regs_q[wb_addr] <= wb_data;
      wr_count_q      <= wr_count_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return '0;
    end else if (wb_we && (addr == wb_addr)) begin
      return wb_data;
    end
    return regs_q[addr];
  endfunction

  assign rs_data  = read_port(rs_addr);
  assign rt_data  = read_port(rt_addr);
  assign wr_count = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module  : tb_wb_regfile
// Purpose : Self-checking bench for wb_regfile against an array-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] WB_PC_4 = '0;
  logic [1:0]  WB_RegDst = '0;
  logic [1:0]  WB_MemToReg = '0;
  logic        WB_RegWr = 1'b0;
  logic [31:0] WB_ALUOut = '0;
  logic [31:0] WB_dataMEMOut = '0;
  logic [4:0]  WB_Rt = '0;
  logic [4:0]  WB_Rd = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [15:0] wr_count;

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] model [32];
  int unsigned model_cnt = 0;

  wb_regfile #(.DATA_W(32), .RA_REG(31), .XP_REG(26)) dut (
    .clk(clk), .reset(reset), .WB_PC_4(WB_PC_4), .WB_RegDst(WB_RegDst),
    .WB_MemToReg(WB_MemToReg), .WB_RegWr(WB_RegWr), .WB_ALUOut(WB_ALUOut),
    .WB_dataMEMOut(WB_dataMEMOut), .WB_Rt(WB_Rt), .WB_Rd(WB_Rd),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_dest();
    case (WB_RegDst)
      2'd0:    return WB_Rt;
      2'd1:    return WB_Rd;
      2'd2:    return 5'd31;
      default: return 5'd26;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata();
    case (WB_MemToReg)
      2'd0:    return WB_ALUOut;
      2'd1:    return WB_dataMEMOut;
      2'd2:    return WB_PC_4;
      default: return WB_PC_4 - 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic ew,
                                           input logic [4:0] ea, input logic [31:0] ed);
    if (a == 5'd0) return 32'd0;
    if (ew && a == ea) return ed;
    return model[a];
  endfunction

  // Inputs are already driven (just after a negedge); check, then commit.
  task automatic do_cycle(input string tag);
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        ew;
    #1;
    ea = exp_dest();
    ed = exp_wdata();
    ew = reset && WB_RegWr && (ea != 5'd0);
    check({tag, ":we"},    {31'd0, wb_we}, {31'd0, ew});
    check({tag, ":addr"},  {27'd0, wb_addr}, {27'd0, ea});
    check({tag, ":data"},  wb_data, ed);
    check({tag, ":rs"},    rs_data, exp_read(rs_addr, ew, ea, ed));
    check({tag, ":rt"},    rt_data, exp_read(rt_addr, ew, ea, ed));
    check({tag, ":cnt"},   {16'd0, wr_count}, {16'd0, 16'(model_cnt)});
    @(posedge clk);
    if (ew) begin
      model[ea] = ed;
      model_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [1:0] dst, input logic [1:0] m2r,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] rsa, input logic [4:0] rta);
    WB_RegWr = we; WB_RegDst = dst; WB_MemToReg = m2r;
    WB_ALUOut = alu; WB_dataMEMOut = mem; WB_PC_4 = pc4;
    WB_Rt = rt; WB_Rd = rd; rs_addr = rsa; rt_addr = rta;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Post-reset: every address reads zero
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 2'd0, 2'd0, '0, '0, '0, 5'd0, 5'd0, 5'(i), 5'(31 - i));
      do_cycle("rst_read");
    end

    drive(1'b1, 2'b01, 2'b00, 32'h1234_5678, '0, '0, 5'd0, 5'd5, 5'd5, 5'd0);
    #1 check("bypass_rd5", rs_data, 32'h1234_5678);
    do_cycle("wr_rd5");
    check("cnt_after_rd5", {16'd0, wr_count}, 32'd1);

    drive(1'b1, 2'b00, 2'b00, 32'hDEAD_BEEF, '0, '0, 5'd0, 5'd0, 5'd0, 5'd5);
    do_cycle("wr_r0");
    drive(1'b0, 2'b00, 2'b00, '0, '0, '0, 5'd0, 5'd0, 5'd0, 5'd5);
    do_cycle("rd_after_r0");

    drive(1'b1, 2'b10, 2'b10, '0, '0, 32'h0040_0010, 5'd0, 5'd0, 5'd0, 5'd0);
    do_cycle("link");
    drive(1'b1, 2'b11, 2'b11, '0, '0, 32'h0, 5'd0, 5'd0, 5'd31, 5'd26);
    do_cycle("xp");
    drive(1'b0, 2'b00, 2'b00, '0, '0, '0, 5'd0, 5'd0, 5'd31, 5'd26);
    #1;
    check("ra_const", rs_data, 32'h0040_0010);
    check("xp_const", rt_data, 32'hFFFF_FFFC);
    do_cycle("rd_ra_xp");

    drive(1'b1, 2'b01, 2'b01, '0, 32'hA5A5_A5A5, '0, 5'd0, 5'd7, 5'd7, 5'd7);
    #1 check("dual_bypass", rt_data, 32'hA5A5_A5A5);
    do_cycle("dual_wr7");
    WB_RegWr = 1'b0;
    do_cycle("dual_rd7");

    // Async reset pulse between edges while a write is pending
    drive(1'b1, 2'b01, 2'b00, 32'h0BAD_CAFE, '0, '0, 5'd0, 5'd9, 5'd5, 5'd31);
    #2 reset = 1'b0;
    #1;
    check("arst_rs",  rs_data, 32'd0);
    check("arst_rt",  rt_data, 32'd0);
    check("arst_we",  {31'd0, wb_we}, 32'd0);
    check("arst_cnt", {16'd0, wr_count}, 32'd0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    model_cnt = 0;
    @(posedge clk);
    #1;
    rs_addr = 5'd9;
    #1;
    check("arst_nowr", rs_data, 32'd0);
    check("arst_cnt2", {16'd0, wr_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 2'b00, 2'b00, '0, '0, '0, 5'd0, 5'd0, 5'd9, 5'd7);
    do_cycle("post_arst");

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), $urandom, $urandom,
            $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 1) == 1) rs_addr = exp_dest();
      if ($urandom_range(0, 2) == 0) rt_addr = exp_dest();
      do_cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and general register file of the 5-stage MIPS pipeline.
- Consumes the WB-side outputs of the MEM/WB pipeline register.
- Selects the destination register and write data, then commits the write on the clock edge.
- Serves the two ID-stage read ports with same-cycle write bypass, and exports the committed write to the forwarding unit.

Parameters:
- DATA_W, 32, register and datapath width
- RA_REG, 31, destination index for link writes (RegDst=2'b10)
- XP_REG, 26, destination index for exception-return writes (RegDst=2'b11)

Ports:
- clk  in  1  clock; all writes on rising edge
- reset  in  1  asynchronous, active-low
- WB_PC_4  in  32  PC+4 of the instruction in WB
- WB_RegDst  in  2  00 Rt, 01 Rd, 10 RA_REG, 11 XP_REG
- WB_MemToReg  in  2  00 ALUOut, 01 dataMEMOut, 10 PC_4, 11 PC_4-4
- WB_RegWr  in  1  write enable
- WB_ALUOut  in  32  ALU result
- WB_dataMEMOut  in  32  load data
- WB_Rt  in  5  rt field
- WB_Rd  in  5  rd field
- rs_addr  in  5  ID read port 1 address
- rt_addr  in  5  ID read port 2 address
- rs_data  out  32  read port 1 data
- rt_data  out  32  read port 2 data
- wb_we  out  1  effective write enable this cycle (to forwarding unit)
- wb_addr  out  5  effective destination index
- wb_data  out  32  selected write-back data
- wr_count  out  16  number of committed writes since reset

Behaviour:
- Storage: 32 x DATA_W array. Index 0 is hardwired zero: never written, always reads 0.
- Destination decode (combinational): wb_addr = Rt / Rd / RA_REG / XP_REG per WB_RegDst.
- Data select (combinational): wb_data = ALUOut / dataMEMOut / PC_4 / PC_4-32'd4 per WB_MemToReg. PC_4-4 is modulo 2^32, so PC_4=0 gives 32'hFFFF_FFFC.
- Effective enable: wb_we = reset & WB_RegWr & (wb_addr != 0).
- When wb_we=0, wb_addr and wb_data still show the decoded values. Consumers must qualify them with wb_we.
- Write: on posedge clk with wb_we=1, regs[wb_addr] <= wb_data. Single-cycle latency.
- Read ports are combinational, including the bypass path.
  - If addr==0, output 0.
  - Else if wb_we and addr==wb_addr, output wb_data (write-first bypass, so the ID stage sees the WB value in the same cycle).
  - Else output regs[addr].
- Both read ports may name the same register. Both may bypass simultaneously.
- wr_count increments by 1 on each posedge with wb_we=1, wrapping 16'hFFFF -> 0. Writes to $0 are not counted.
- Reset asserted (async, any time, including mid-write cycle):
  - All 32 registers and wr_count clear to 0 immediately.
  - rs_data = rt_data = 0, wb_we = 0.
  - No write is committed on any edge while reset=0.
- Reset release: the first write can occur on the first rising edge with reset=1.
- No X propagation: all selects are fully decoded, so every 2-bit code has a defined result.

Test Plan:
- Reset, then read all 32 addresses on rs/rt -> all 0. wr_count=0, wb_we=0.
- RegWr=1, RegDst=01, Rd=5, MemToReg=00, ALUOut=32'h1234_5678; same cycle rs_addr=5 -> rs_data=32'h1234_5678 (bypass). After edge, regs[5] holds the value and wr_count=1.
- RegWr=1, RegDst=00, Rt=0, ALUOut=32'hDEAD_BEEF -> wb_we=0. After edge rs_addr=0 reads 0 and wr_count is unchanged.
- RegDst=10, MemToReg=10, PC_4=32'h0040_0010 -> regs[31]=32'h0040_0010. Then RegDst=11, MemToReg=11, PC_4=0 -> regs[26]=32'hFFFF_FFFC.
- MemToReg=01, dataMEMOut=32'hA5A5_A5A5, Rd=7, with rs_addr=rt_addr=7 -> both ports read 32'hA5A5_A5A5 in the same cycle. Next cycle RegWr=0: both still read it from storage.
- Load several registers, then pulse reset low between edges while RegWr=1 -> registers and wr_count read 0 immediately, and no write is committed at the next edge while reset is low.
